// File: rtl/dlx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dlx_sequencer
// Purpose : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for DLX.
// Rev     : 1.0  initial release
// ============================================================================
module dlx_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             i_req,
  input  logic             i_ack,
  output logic             d_req,
  output logic             d_we,
  input  logic             d_ack,
  input  logic             d_load_enable,
  input  logic             d_write_enable,
  input  logic [4:0]       Rd,
  output logic             ID,
  output logic             EX,
  output logic             rf_write,
  output logic             pc_update,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  state_t           r_state;
  logic [7:0]       r_wait;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic w_mem_op;
  logic w_rd_nz;
  logic w_retire;

  assign w_mem_op = d_load_enable | d_write_enable;
  assign w_rd_nz  = |Rd;

  // Retirement is the last cycle of an instruction; it may end in EXEC, MEM or WB.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_EXEC:  w_retire = ~w_mem_op & ~w_rd_nz;
      S_MEM:   w_retire = d_ack & ~(d_load_enable & w_rd_nz);
      S_WB:    w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + CNT_W'(1);
      r_wait  <= '0;
      r_state <= run ? S_FETCH : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
          end
        end
        S_FETCH: begin
          if (i_ack) begin
            r_state <= S_DECODE;
          end else if (r_wait == c_timeout) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_mem_op) begin
            r_state <= S_MEM;
            r_wait  <= '0;
          end else begin
            r_state <= S_WB;
          end
        end
        // A non-retiring ack in MEM is a load with a live destination.
        S_MEM: begin
          if (d_ack) begin
            r_state <= S_WB;
          end else if (r_wait == c_timeout) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB, S_ERR: r_state <= r_state;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign state       = r_state;
  assign i_req       = (r_state == S_FETCH);
  assign ID          = (r_state == S_DECODE);
  assign EX          = (r_state == S_EXEC);
  assign d_req       = (r_state == S_MEM);
  assign d_we        = (r_state == S_MEM) & d_write_enable;
  assign rf_write    = (r_state == S_WB);
  assign pc_update   = w_retire;
  assign err         = r_err;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: doc/dlx_sequencer.md
Name: dlx_sequencer

Overview:
- Multi-cycle control sequencer for the DLX core. Steps each instruction through the FETCH, DECODE, EXEC, MEM and WB phases.
- Drives the instruction-memory and data-memory request/ack handshakes, the decoder's ID strobe, and the register-file write and PC-update strobes.
- Consumes the registered decoder outputs (d_load_enable, d_write_enable, Rd) to decide whether to skip MEM and/or WB.
- Detects memory-handshake timeouts and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for an ack before the error trap (range 1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous reset, active-high
- run  input  1  1 = keep executing; 0 = park in IDLE at the next instruction boundary
- i_req  output  1  instruction-memory read request
- i_ack  input  1  instruction word valid on i_data_read this cycle
- d_req  output  1  data-memory access request
- d_we  output  1  data-memory write (store) qualifier, valid while d_req=1
- d_ack  input  1  data access complete this cycle
- d_load_enable  input  1  decoder: current instruction is a load
- d_write_enable  input  1  decoder: current instruction is a store
- Rd  input  5  decoder: destination register
- ID  output  1  decode strobe to decoder
- EX  output  1  execute-phase strobe (ALU result capture)
- rf_write  output  1  register-file write enable
- pc_update  output  1  one-cycle pulse at instruction retirement
- err  output  1  sticky memory-timeout flag
- state  output  3  current state encoding, for debug and verification
- instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high.
  - reset is sampled only on the rising edge of clk and overrides all other inputs.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6. Value 7 is unused and recovers to IDLE on the next clock.
- Outputs are Moore-decoded from the state register, except pc_update (see below):
  - i_req=1 iff state is FETCH.
  - ID=1 iff state is DECODE.
  - EX=1 iff state is EXEC.
  - d_req=1 iff state is MEM; d_we=d_write_enable while in MEM, else 0.
  - rf_write=1 iff state is WB.
- Reset values: state=IDLE, wait counter=0, err=0, instr_count=0. Consequently all strobes are 0 and pc_update=0.
- Transitions:
  - IDLE: to FETCH if run=1, else stay in IDLE.
  - FETCH: to DECODE on i_ack=1; otherwise stay.
  - DECODE: always to EXEC after 1 cycle. Decoder outputs are valid from EXEC onward and held until the next ID.
  - EXEC:
    - to MEM if d_load_enable or d_write_enable;
    - else to WB if Rd != 0;
    - else retire.
  - MEM, on d_ack=1:
    - load with Rd != 0: to WB;
    - load with Rd = 0, or store: retire.
    - Otherwise stay in MEM.
  - WB: retire after 1 cycle.
  - Retire: pc_update=1 for that cycle, instr_count increments (wraps modulo 2^CW), next state is FETCH if run=1, else IDLE.
- Handshakes:
  - Acks are sampled on the clock edge.
  - An ack arriving while the matching req is low is ignored.
  - Simultaneous i_ack and d_ack are legal; only the ack matching the current state is used.
- Timeout:
  - The 8-bit wait counter clears on entry to FETCH or MEM.
  - It increments on each FETCH/MEM cycle without the matching ack.
  - When the counter equals MEM_TIMEOUT with still no ack, the next state is ERR and err is set.
  - An ack in the same cycle as the timeout wins: no error.
- ERR: all strobes are 0 and err stays 1; exited only by reset.
- run=0 mid-instruction has no effect until retirement.
- Reset mid-operation abandons any outstanding request. i_req/d_req drop the cycle after reset is sampled. Late acks are ignored.
- Minimum latency with zero-wait acks:
  - jump without link (Rd=0, no mem): 3 cycles;
  - ALU: 4 cycles;
  - store: 4 cycles;
  - load: 5 cycles.

Test Plan:
- Reset, run=1, i_ack tied 1, ALU instruction with Rd=3 -> state sequence 1,2,3,5 then retire; pc_update high exactly in the WB cycle; instr_count=1 after 4 cycles; rf_write high for 1 cycle.
- Load with Rd=7, d_ack delayed 2 cycles -> d_req high 3 cycles with d_we=0; then WB; total 7 cycles; instr_count increments once.
- Store, d_ack immediate -> d_req=1 and d_we=1 for 1 cycle; no WB (rf_write stays 0); pc_update in the MEM cycle.
- MEM_TIMEOUT=15, i_ack never asserted -> i_req high 16 cycles, then state=6, err=1, i_req=0. Apply reset -> state=0, err=0. Separately, i_ack on the 16th cycle -> DECODE, err=0.
- run dropped during EXEC of an ALU instruction -> instruction completes through WB, then state=0 (IDLE) with i_req=0; run=1 again -> FETCH the next cycle.
- Reset asserted in MEM while d_req=1 and d_ack arriving the next cycle -> state=0, d_req=0, instr_count=0; the late d_ack is ignored.
